// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, almost flags,
// overflow/underflow pulses, synchronous flush and registered or FWFT read.
module sync_fifo #(
  parameter int DEPTH         = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = $clog2(DEPTH) + 1,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter bit FWFT          = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr
);

  localparam int IW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AF_LEVEL  = ADDR_WIDTH'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH-1:0] AE_LEVEL  = ADDR_WIDTH'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  assign wr_idx = wr_ptr[IW-1:0];
  assign rd_idx = rd_ptr[IW-1:0];

  // Full when the pointers sit on the same slot but one has lapped the other.
  assign full         = (wr_ptr[ADDR_WIDTH-1] != rd_ptr[ADDR_WIDTH-1]) && (wr_idx == rd_idx);
  assign empty        = (wr_ptr == rd_ptr);
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign rd_data  = FWFT ? mem[rd_idx] : rd_data_q;
  assign rd_valid = FWFT ? !empty : rd_valid_q;

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_valid_q <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
      rd_valid_q <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + ONE;
        rd_data_q <= mem[rd_idx];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one DEPTH=8 registered-read instance and one
// DEPTH=8 FWFT instance, checked with immediate assertions against hand values.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       a_rst = 1'b1, a_flush = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
  logic [7:0] a_wd = 8'h00;
  logic [7:0] a_rdata;
  logic       a_rvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_count, a_wptr, a_rptr;

  logic       f_rst = 1'b1, f_flush = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_wd = 8'h00;
  logic [7:0] f_rdata;
  logic       f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] f_count, f_wptr, f_rptr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DEPTH(8), .DATA_WIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(1'b0)) dut_reg (
    .clk(clk), .rst(a_rst), .flush(a_flush), .wr_en(a_wr), .wr_data(a_wd), .rd_en(a_rd),
    .rd_data(a_rdata), .rd_valid(a_rvalid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .overflow(a_ovf),
    .underflow(a_unf), .wr_ptr(a_wptr), .rd_ptr(a_rptr)
  );

  sync_fifo #(.DEPTH(8), .DATA_WIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(f_rst), .flush(f_flush), .wr_en(f_wr), .wr_data(f_wd), .rd_en(f_rd),
    .rd_data(f_rdata), .rd_valid(f_rvalid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_unf), .wr_ptr(f_wptr), .rd_ptr(f_rptr)
  );

  // Drive the registered-read instance, then sample 1 ns after the edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] wd, input logic rd,
                               input logic fl, input logic rs);
    a_wr    = wr;
    a_wd    = wd;
    a_rd    = rd;
    a_flush = fl;
    a_rst   = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    f_rst = 1'b0;
    checkOutput("rst_count", a_count, 0);
    checkOutput("rst_empty", a_empty, 1);
    checkOutput("rst_full", a_full, 0);
    checkOutput("rst_aempty", a_ae, 1);
    checkOutput("rst_afull", a_af, 0);
    checkOutput("rst_rdata", a_rdata, 8'h00);
    checkOutput("rst_rvalid", a_rvalid, 0);
    checkOutput("rst_ovf", a_ovf, 0);
    checkOutput("rst_unf", a_unf, 0);
    checkOutput("rst_ptrs", {a_wptr, a_rptr}, 8'h00);
    checkOutput("f_rst_flags", {f_empty, f_full, f_ae, f_af, f_ovf, f_unf, f_rvalid}, 7'b1010000);
    checkOutput("f_rst_cnt_ptrs", {f_count, f_wptr, f_rptr}, 12'h000);

    // Fill with 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      checkOutput("fill_count", a_count, 32'(i + 1));
      checkOutput("fill_afull", a_af, 32'((i + 1) >= 6));
      checkOutput("fill_aempty", a_ae, 32'((i + 1) <= 1));
    end
    checkOutput("fill_full", a_full, 1);
    checkOutput("fill_wptr", a_wptr, 8);

    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_pulse", a_ovf, 1);
    checkOutput("ovf_wptr", a_wptr, 8);
    checkOutput("ovf_count", a_count, 8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_clear", a_ovf, 0);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("drain_data", a_rdata, 32'(8'h10 + i));
      checkOutput("drain_valid", a_rvalid, 1);
      checkOutput("drain_count", a_count, 32'(7 - i));
    end
    checkOutput("drain_empty", a_empty, 1);
    checkOutput("drain_rptr", a_rptr, 8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_valid_drop", a_rvalid, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("unf_pulse", a_unf, 1);
    checkOutput("unf_rptr", a_rptr, 8);
    checkOutput("unf_rdata_hold", a_rdata, 8'h17);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("unf_clear", a_unf, 0);

    // Wrap: 20 write/read pairs starting from pointer 8
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_count_w", a_count, 1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("wrap_data", a_rdata, 32'(i));
      if (i == 7) checkOutput("wrap_rptr_zero", a_rptr, 0);
    end
    checkOutput("wrap_ptrs", {a_wptr, a_rptr}, 8'hCC);

    // Simultaneous ops at full
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("sim_full_pre", a_full, 1);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    checkOutput("sim_full_data", a_rdata, 8'h20);
    checkOutput("sim_full_ovf", a_ovf, 1);
    checkOutput("sim_full_count", a_count, 7);
    checkOutput("sim_full_flag", a_full, 0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("sim_full_drain", a_rdata, 32'(8'h20 + i));
    end
    checkOutput("sim_full_empty", a_empty, 1);

    // Simultaneous ops at empty
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    checkOutput("sim_empty_unf", a_unf, 1);
    checkOutput("sim_empty_count", a_count, 1);
    checkOutput("sim_empty_valid", a_rvalid, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("sim_empty_data", a_rdata, 8'hA5);
    checkOutput("sim_empty_count2", a_count, 0);

    // Simultaneous ops mid-occupancy keep count
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b1, 1'b0, 1'b0);
    checkOutput("sim_mid_count", a_count, 1);
    checkOutput("sim_mid_data", a_rdata, 8'h31);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("sim_mid_data2", a_rdata, 8'h32);

    // Flush mid-stream with a write in the same cycle
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("flush_pre_count", a_count, 5);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_count", a_count, 0);
    checkOutput("flush_empty", a_empty, 1);
    checkOutput("flush_ovf", a_ovf, 0);
    checkOutput("flush_ptrs", {a_wptr, a_rptr}, 8'h00);
    checkOutput("flush_rdata_hold", a_rdata, 8'h32);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_after_data", a_rdata, 8'h77);

    // Same again with reset
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0, 1'b1);
    checkOutput("rst2_count", a_count, 0);
    checkOutput("rst2_empty", a_empty, 1);
    checkOutput("rst2_rdata", a_rdata, 8'h00);
    checkOutput("rst2_ovf", a_ovf, 0);
    checkOutput("rst2_wptr", a_wptr, 0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("rst2_after_data", a_rdata, 8'h77);

    // FWFT instance: word shows without rd_en
    f_wr = 1'b1;
    f_wd = 8'h3C;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    f_wr = 1'b0;
    checkOutput("fwft_data", f_rdata, 8'h3C);
    checkOutput("fwft_valid", f_rvalid, 1);
    checkOutput("fwft_count", f_count, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("fwft_hold", f_rdata, 8'h3C);
    checkOutput("fwft_hold_valid", f_rvalid, 1);
    f_rd = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    f_rd = 1'b0;
    checkOutput("fwft_pop_empty", f_empty, 1);
    checkOutput("fwft_pop_valid", f_rvalid, 0);
    f_wr = 1'b1;
    f_wd = 8'h11;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    f_wd = 8'h22;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    f_wr = 1'b0;
    checkOutput("fwft_two_head", f_rdata, 8'h11);
    f_rd = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    f_rd = 1'b0;
    checkOutput("fwft_two_next", f_rdata, 8'h22);
    checkOutput("fwft_two_count", f_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
